// File: rtl/rd_ptr_handler_pkg.sv
// Shared definitions for the async FIFO pointer handlers (read and write sides).
package rd_ptr_handler_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Out-of-range stage counts fall back to the nearest legal value.
    function automatic int legal_sync_stages(input int stages);
        if (stages < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (stages > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return stages;
    endfunction

endpackage

// File: rtl/rd_ptr_handler_sync_nff.sv
// Generic multi-flop synchroniser; also used by the write side for rd_ptr_gray.
module sync_nff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_handler.sv
// Read-side pointer and flag controller of the async FIFO.
import rd_ptr_handler_pkg::*;

module rd_ptr_handler #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  clr_underflow,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_bin,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  rd_underflow
);

    localparam int PW       = ADDR_WIDTH + 1;
    localparam int DEPTH    = fifo_depth(ADDR_WIDTH);
    localparam int SYNC_N   = legal_sync_stages(SYNC_STAGES);
    localparam int AE_CLAMP = (AE_THRESH > DEPTH) ? DEPTH : AE_THRESH;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_CLAMP);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic          rd_inc;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] count_next;

    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_N)
    ) u_wq_sync (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .d     (wr_ptr_gray),
        .q     (wq_gray)
    );

    assign wq_bin     = gray2bin(wq_gray);
    assign rd_inc     = rd_en & ~rd_empty;
    assign bin_next   = rd_ptr_bin + {{ADDR_WIDTH{1'b0}}, rd_inc};
    assign gray_next  = bin2gray(bin_next);
    // Flags look ahead at the post-read pointer so the last read blocks the next one.
    assign count_next = wq_bin - bin_next;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rd_ptr_bin      <= '0;
            rd_ptr_gray     <= '0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_count        <= '0;
            rd_underflow    <= 1'b0;
        end else begin
            rd_ptr_bin      <= bin_next;
            rd_ptr_gray     <= gray_next;
            rd_empty        <= (gray_next == wq_gray);
            rd_count        <= count_next;
            rd_almost_empty <= (count_next <= AE_LIMIT);
            rd_underflow    <= (rd_en & rd_empty) | (rd_underflow & ~clr_underflow);
        end
    end

    assign rd_addr = rd_ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_rd_ptr_handler.sv
// Randomised bench for rd_ptr_handler against an occupancy-level reference model.
module tb_rd_ptr_handler;

    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int AE    = 1;
    localparam int PW    = AW + 1;
    localparam int PMOD  = 1 << PW;
    localparam int DEPTH = 1 << AW;

    logic          rd_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_underflow = 1'b0;
    logic [PW-1:0] wr_ptr_gray;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] rd_ptr_gray;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [PW-1:0] rd_count;
    logic          rd_underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int w_bin   = 0;
    bit chk_on  = 1'b1;

    always #5 rd_clk = ~rd_clk;

    function automatic logic [PW-1:0] gray_of(input int w);
        int v;
        v = w % PMOD;
        return PW'(v ^ (v >> 1));
    endfunction

    assign wr_ptr_gray = gray_of(w_bin);

    rd_ptr_handler #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .AE_THRESH   (AE)
    ) dut (
        .rd_clk          (rd_clk),
        .rst_n           (rst_n),
        .rd_en           (rd_en),
        .clr_underflow   (clr_underflow),
        .wr_ptr_gray     (wr_ptr_gray),
        .rd_addr         (rd_addr),
        .rd_ptr_bin      (rd_ptr_bin),
        .rd_ptr_gray     (rd_ptr_gray),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_count        (rd_count),
        .rd_underflow    (rd_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge rd_clk);
            #2;
        end
    endtask

    // Reference model: the read side sees the write count from SS edges ago.
    int m_rp, m_count, seen;
    bit m_empty, m_ae, m_uf, m_rst_edge, rd_ok;
    int pipe[$];

    always @(posedge rd_clk) begin
        if (!rst_n) begin
            m_rp = 0; m_count = 0; m_empty = 1; m_ae = 1; m_uf = 0; m_rst_edge = 1;
            pipe.delete();
            for (int i = 0; i < SS; i++) pipe.push_back(0);
        end else begin
            m_rst_edge = 0;
            seen = pipe.pop_front();
            pipe.push_back(w_bin % PMOD);
            rd_ok = rd_en && !m_empty;
            m_uf  = (rd_en && m_empty) || (m_uf && !clr_underflow);
            if (rd_ok) m_rp = (m_rp + 1) % PMOD;
            m_count = (seen - m_rp + PMOD) % PMOD;
            m_empty = (m_count == 0);
            m_ae    = (m_count <= AE);
        end
    end

    logic [PW-1:0] prev_gray, prev_bin;
    bit have_prev = 0;
    int wraps = 0;

    always @(negedge rd_clk) begin
        if (chk_on) begin
            check("rd_ptr_bin", rd_ptr_bin, m_rp);
            check("rd_addr", rd_addr, m_rp % DEPTH);
            check("rd_ptr_gray", rd_ptr_gray, gray_of(m_rp));
            check("rd_empty", rd_empty, m_empty);
            check("rd_almost_empty", rd_almost_empty, m_ae);
            check("rd_count", rd_count, m_count);
            check("rd_underflow", rd_underflow, m_uf);
            if (have_prev && !m_rst_edge) begin
                check("gray_step", $countones(prev_gray ^ rd_ptr_gray) <= 1, 1);
                if (prev_bin == PW'(PMOD - 1) && rd_ptr_bin == '0) wraps++;
            end
            prev_gray = rd_ptr_gray;
            prev_bin  = rd_ptr_bin;
            have_prev = 1;
        end
    end

    initial begin
        // Reset with idle inputs
        rst_n = 0; w_bin = 0;
        tick(2);
        check("rst_empty", rd_empty, 1);
        check("rst_ae", rd_almost_empty, 1);
        check("rst_count", rd_count, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_gray", rd_ptr_gray, 0);
        check("rst_uf", rd_underflow, 0);
        rst_n = 1;

        // Write-to-flag latency, then a single read of that entry
        w_bin = 1;
        tick(1);
        check("lat_k_empty", rd_empty, 1);
        tick(1);
        check("lat_k1_empty", rd_empty, 1);
        tick(1);
        check("lat_k2_empty", rd_empty, 0);
        check("lat_k2_count", rd_count, 1);
        rd_en = 1;
        tick(1);
        rd_en = 0;
        check("rd1_addr", rd_addr, 1);
        check("rd1_gray", rd_ptr_gray, 5'b00001);
        check("rd1_empty", rd_empty, 1);
        check("rd1_count", rd_count, 0);

        // Underflow set, hold, clear, set-beats-clear
        rd_en = 1;
        tick(1);
        rd_en = 0;
        check("uf_ptr_hold", rd_ptr_bin, 1);
        check("uf_set", rd_underflow, 1);
        tick(1);
        check("uf_held", rd_underflow, 1);
        clr_underflow = 1;
        tick(1);
        check("uf_clr", rd_underflow, 0);
        rd_en = 1;
        tick(1);
        rd_en = 0;
        check("uf_set_wins", rd_underflow, 1);
        tick(1);
        clr_underflow = 0;
        check("uf_clr2", rd_underflow, 0);

        // Full drain from a full FIFO
        rst_n = 0; w_bin = 0;
        tick(2);
        rst_n = 1;
        w_bin = 16;
        tick(3);
        check("full_count", rd_count, 16);
        check("full_ae", rd_almost_empty, 0);
        check("full_addr0", rd_addr, 0);
        rd_en = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1);
            check("drain_addr", rd_addr, i % DEPTH);
            if (i == DEPTH - 2) check("drain_ae_off", rd_almost_empty, 0);
            if (i == DEPTH - 1) check("drain_ae_on", rd_almost_empty, 1);
        end
        rd_en = 0;
        check("drain_empty", rd_empty, 1);
        check("drain_ptr", rd_ptr_bin, 16);

        // Random streaming across several pointer wraps
        for (int c = 0; c < 400; c++) begin
            if (((w_bin - m_rp + 4 * PMOD) % PMOD) < DEPTH && ($urandom_range(0, 99) < 55))
                w_bin = (w_bin + 1) % PMOD;
            rd_en = ($urandom_range(0, 99) < 50);
            clr_underflow = ($urandom_range(0, 99) < 10);
            tick(1);
        end
        rd_en = 0; clr_underflow = 0;
        check("wraps_seen", wraps > 0, 1);

        // Reset in the middle of a drain
        rst_n = 0; w_bin = 0;
        tick(2);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            w_bin = w_bin + 1;
            tick(1);
        end
        tick(3);
        check("mid_count5", rd_count, 5);
        rst_n = 0; rd_en = 1; w_bin = 0;
        tick(1);
        check("mid_rst_ptr", rd_ptr_bin, 0);
        check("mid_rst_empty", rd_empty, 1);
        check("mid_rst_count", rd_count, 0);
        check("mid_rst_uf", rd_underflow, 0);
        rst_n = 1; rd_en = 0;
        w_bin = 1;
        tick(2);
        check("post_rst_k1", rd_empty, 1);
        tick(1);
        check("post_rst_k2", rd_empty, 0);
        check("post_rst_count", rd_count, 1);
        tick(2);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
